apb_gpio_bank: RTL and testbench

//  Parametrised APB slave GPIO bank; successor to the fixed 8-bit APB/GPIO pair.

---
 rtl/apb_gpio_bank.sv | 224 ++++++++++++++++++++++
 tb/tb_apb_gpio_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_bank.sv
// ---------------------------------------------------------------------------
// apb_gpio_bank
// Parametrised APB slave GPIO bank. Provides per-pin output data and
// direction, atomic set/clear of the output register, synchronised inputs,
// and edge-triggered interrupts with write-1-to-clear status. Reads can be
// stretched by a fixed number of wait states; writes always complete at once.
//
// Parameters
//   WIDTH        pin count (1..32), registers zero-extended on PRDATA
//   SYNC_STAGES  input synchroniser depth (2..4)
//   READ_WAIT    PREADY-low cycles inserted on reads (0..3)
//
// Ports
//   PCLK, PRESETn                  bus clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE          APB control
//   PADDR[3:0]                     register word index
//   PWDATA[31:0], PRDATA[31:0]     write / read data
//   PREADY, PSLVERR                transfer complete, error flag
//   gpio_i[WIDTH]                  asynchronous pad inputs
//   gpio_o[WIDTH], gpio_oe[WIDTH]  pad output values and output enables
//   irq                            registered level interrupt
//
// Register map: 0 DOUT, 1 DIR, 2 DIN (RO), 3 IRQ_EN, 4 IRQ_POL (1=rising),
//               5 IRQ_STAT (W1C), 6 DOUT_SET (WO), 7 DOUT_CLR (WO)
// ---------------------------------------------------------------------------
module apb_gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int READ_WAIT   = 0
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [3:0]       PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    // SETUP holds while the bus is selected and waiting for PENABLE; the
    // cycle in which SETUP sees PENABLE is the access phase.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } bus_state_t;

    // The first stalled cycle is the access cycle itself, so the counter
    // loads one less than the requested number of wait states.
    localparam logic [1:0] WAIT_INIT = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

    bus_state_t       state_r, state_s;
    logic [1:0]       wait_cnt_r, wait_cnt_s;
    logic             access_s, read_stall_s, pready_s;
    logic             addr_err_s, wr_err_s, commit_s;
    logic [WIDTH-1:0] wdata_s, w1c_s, rd_data_s;
    logic [WIDTH-1:0] dout_r, dir_r, irq_en_r, irq_pol_r, irq_stat_r, prev_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] din_s, rise_s, fall_s, evt_s;
    logic             irq_r;
    logic             unused_pwdata_s;

    assign wdata_s         = PWDATA[WIDTH-1:0];
    assign unused_pwdata_s = ^PWDATA;
    assign din_s           = sync_r[SYNC_STAGES-1];

    assign access_s     = PSEL & PENABLE & ((state_r == ST_SETUP) | (state_r == ST_WAIT));
    assign read_stall_s = access_s & ~PWRITE & (state_r == ST_SETUP) & (READ_WAIT > 0);
    assign addr_err_s   = PADDR[3];
    assign wr_err_s     = PWRITE & (PADDR == 4'd2);
    assign commit_s     = access_s & PWRITE & pready_s & ~addr_err_s & ~wr_err_s;
    assign w1c_s        = (commit_s && (PADDR == 4'd5)) ? wdata_s : {WIDTH{1'b0}};

    assign rise_s = din_s & ~prev_r;
    assign fall_s = ~din_s & prev_r;
    assign evt_s  = (irq_pol_r & rise_s) | (~irq_pol_r & fall_s);

    assign PREADY  = pready_s;
    assign PSLVERR = access_s & pready_s & (addr_err_s | wr_err_s);
    assign gpio_o  = dout_r;
    assign gpio_oe = dir_r;
    assign irq     = irq_r;

    // PREADY: low while stalling a read, including the first access cycle.
    always_comb begin
        pready_s = 1'b1;
        if (state_r == ST_WAIT) begin
            pready_s = (wait_cnt_r == 2'd0);
        end else if (read_stall_s) begin
            pready_s = 1'b0;
        end else begin
            pready_s = 1'b1;
        end
    end

    // Bus FSM next-state and wait counter.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!PSEL) begin
                    state_s = ST_IDLE;
                end else if (read_stall_s) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = WAIT_INIT;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_s = ST_IDLE;
                end else if (wait_cnt_r == 2'd0) begin
                    state_s = ST_SETUP;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                wait_cnt_s = 2'd0;
            end
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Read data mux; write-only and unmapped indices read as zero.
    always_comb begin
        rd_data_s = {WIDTH{1'b0}};
        case (PADDR)
            4'd0:    rd_data_s = dout_r;
            4'd1:    rd_data_s = dir_r;
            4'd2:    rd_data_s = din_s;
            4'd3:    rd_data_s = irq_en_r;
            4'd4:    rd_data_s = irq_pol_r;
            4'd5:    rd_data_s = irq_stat_r;
            default: rd_data_s = {WIDTH{1'b0}};
        endcase
    end

    // PRDATA is only driven during the access phase.
    always_comb begin
        PRDATA = 32'd0;
        if (access_s) begin
            PRDATA = 32'(rd_data_s);
        end else begin
            PRDATA = 32'd0;
        end
    end

    // Control registers written on a committed APB write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dout_r    <= {WIDTH{1'b0}};
            dir_r     <= {WIDTH{1'b0}};
            irq_en_r  <= {WIDTH{1'b0}};
            irq_pol_r <= {WIDTH{1'b0}};
        end else if (commit_s) begin
            case (PADDR)
                4'd0:    dout_r    <= wdata_s;
                4'd1:    dir_r     <= wdata_s;
                4'd3:    irq_en_r  <= wdata_s;
                4'd4:    irq_pol_r <= wdata_s;
                4'd6:    dout_r    <= dout_r | wdata_s;
                4'd7:    dout_r    <= dout_r & ~wdata_s;
                default: dout_r    <= dout_r;
            endcase
        end
    end

    // Input synchroniser chain; DIN is the last stage.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Edge history, sticky status (a new event beats a same-cycle clear)
    // and the registered interrupt line.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prev_r     <= {WIDTH{1'b0}};
            irq_stat_r <= {WIDTH{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            prev_r     <= din_s;
            irq_stat_r <= (irq_stat_r & ~w1c_s) | evt_s;
            irq_r      <= |(irq_stat_r & irq_en_r);
        end
    end

endmodule

// File: tb/tb_apb_gpio_bank.sv
module tb_apb_gpio_bank;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe;
    logic        irq;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    apb_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .READ_WAIT(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // One APB transfer; expected response goes to the scoreboard, the
    // number of PREADY-low access cycles is checked here.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lows);
        int lows;
        exp_t e;
        e.wr = wr; e.addr = addr; e.rdata = exp_rdata; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            if (PREADY) break;
            lows++;
        end
        check("wait_cycles", 32'(lows), 32'(exp_lows));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Scoreboard monitor: compares every completed transfer with the queue.
    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: addr %0d completed with no expected entry", PADDR);
            end else begin
                mon_e = exp_q.pop_front();
                check("pslverr", 32'(PSLVERR), 32'(mon_e.err));
                if (!mon_e.wr) begin
                    check("prdata", PRDATA, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 4'd0; PWDATA = 32'd0; gpio_i = 8'd0;
        tick(3);
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        PRESETn = 1'b1;
        tick(2);

        // Data register, set and clear: (0xA5 | 0x0F) & ~0x81 = 0x2E
        xfer(1'b1, 4'd0, 32'h0000_00A5, 32'h0, 1'b0, 0);
        check("dout_write", 32'(gpio_o), 32'hA5);
        xfer(1'b1, 4'd6, 32'h0000_000F, 32'h0, 1'b0, 0);
        check("dout_set", 32'(gpio_o), 32'hAF);
        xfer(1'b1, 4'd7, 32'h0000_0081, 32'h0, 1'b0, 0);
        check("dout_clr", 32'(gpio_o), 32'h2E);
        xfer(1'b0, 4'd0, 32'h0, 32'h0000_002E, 1'b0, 2);
        // Upper write bits ignored, read zero-extended
        xfer(1'b1, 4'd0, 32'hFFFF_FF5A, 32'h0, 1'b0, 0);
        check("dout_wide", 32'(gpio_o), 32'h5A);
        xfer(1'b0, 4'd0, 32'h0, 32'h0000_005A, 1'b0, 2);

        // Direction register and wait states
        xfer(1'b1, 4'd1, 32'h0000_00F0, 32'h0, 1'b0, 0);
        check("dir_write", 32'(gpio_oe), 32'hF0);
        xfer(1'b0, 4'd1, 32'h0, 32'h0000_00F0, 1'b0, 2);
        xfer(1'b1, 4'd1, 32'h0000_003C, 32'h0, 1'b0, 0);
        check("dir_write2", 32'(gpio_oe), 32'h3C);

        // Rising-edge interrupt on pin 0
        xfer(1'b1, 4'd3, 32'h0000_0001, 32'h0, 1'b0, 0);
        xfer(1'b1, 4'd4, 32'h0000_0001, 32'h0, 1'b0, 0);
        gpio_i[0] = 1'b1;
        tick(3);
        check("irq_edge3", 32'(irq), 32'h0);
        tick(1);
        check("irq_edge4", 32'(irq), 32'h1);
        xfer(1'b0, 4'd5, 32'h0, 32'h0000_0001, 1'b0, 2);
        xfer(1'b0, 4'd2, 32'h0, 32'h0000_0001, 1'b0, 2);
        xfer(1'b1, 4'd5, 32'h0000_0001, 32'h0, 1'b0, 0);
        check("irq_after_w1c", 32'(irq), 32'h1);
        tick(1);
        check("irq_cleared", 32'(irq), 32'h0);

        // Falling-edge status on pin 3 (not enabled), then set-wins
        gpio_i[3] = 1'b1;
        tick(4);
        gpio_i[3] = 1'b0;
        tick(4);
        xfer(1'b0, 4'd5, 32'h0, 32'h0000_0008, 1'b0, 2);
        check("irq_masked", 32'(irq), 32'h0);
        gpio_i[3] = 1'b1;
        tick(4);
        xfer(1'b0, 4'd5, 32'h0, 32'h0000_0008, 1'b0, 2);
        gpio_i[3] = 1'b0;
        xfer(1'b1, 4'd5, 32'h0000_0008, 32'h0, 1'b0, 0);
        xfer(1'b0, 4'd5, 32'h0, 32'h0000_0008, 1'b0, 2);
        xfer(1'b1, 4'd5, 32'h0000_0008, 32'h0, 1'b0, 0);
        xfer(1'b0, 4'd5, 32'h0, 32'h0000_0000, 1'b0, 2);

        // Error responses leave state untouched
        xfer(1'b1, 4'd2, 32'h0000_00FF, 32'h0, 1'b1, 0);
        xfer(1'b0, 4'd9, 32'h0, 32'h0000_0000, 1'b1, 2);
        xfer(1'b1, 4'd9, 32'h0000_00FF, 32'h0, 1'b1, 0);
        check("err_gpio_o", 32'(gpio_o), 32'h5A);
        check("err_gpio_oe", 32'(gpio_oe), 32'h3C);
        xfer(1'b0, 4'd0, 32'h0, 32'h0000_005A, 1'b0, 2);
        xfer(1'b0, 4'd1, 32'h0, 32'h0000_003C, 1'b0, 2);
        xfer(1'b0, 4'd3, 32'h0, 32'h0000_0001, 1'b0, 2);
        xfer(1'b0, 4'd4, 32'h0, 32'h0000_0001, 1'b0, 2);
        xfer(1'b0, 4'd6, 32'h0, 32'h0000_0000, 1'b0, 2);
        xfer(1'b0, 4'd2, 32'h0, 32'h0000_0001, 1'b0, 2);

        // Raise irq again, then reset in the middle of a read wait state
        gpio_i[0] = 1'b0;
        tick(4);
        gpio_i[0] = 1'b1;
        tick(5);
        check("irq_before_rst", 32'(irq), 32'h1);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("mid_wait_pready", 32'(PREADY), 32'h0);
        #2;
        PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b0;
        #1;
        check("midrst_pready", 32'(PREADY), 32'h1);
        check("midrst_gpio_o", 32'(gpio_o), 32'h0);
        check("midrst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_prdata", PRDATA, 32'h0);
        tick(2);
        PRESETn = 1'b1;
        xfer(1'b0, 4'd0, 32'h0, 32'h0000_0000, 1'b0, 2);
        xfer(1'b0, 4'd5, 32'h0, 32'h0000_0000, 1'b0, 2);

        tick(3);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
